// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between I-cache refill and D-cache refill/writeback,
// running one line burst at a time and routing read beats back to the owning side.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int BURST      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_rvalid,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_wnext,
  output logic [DW-1:0] d_rdata,
  output logic          d_rvalid,
  output logic          d_done,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic [1:0]    owner
);
  localparam int BW = $clog2(BURST);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW-1:0] LINE_MASK = ~(AW'(BURST * 4 - 1));
  localparam logic [BW-1:0] LAST      = BW'(BURST - 1);
  localparam logic [SW-1:0] SMAX      = SW'(STARVE_MAX);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BI   = 2'd1;
  localparam logic [1:0] S_BD   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state;
  logic [AW-1:0] base;
  logic [BW-1:0] beat;
  logic [SW-1:0] starve;
  logic          we_l;
  logic          grant_i;

  // D wins ties until I has watched STARVE_MAX consecutive D grants.
  assign grant_i = i_req && (!d_req || starve == SMAX);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= S_IDLE;
      owner    <= 2'b00;
      base     <= '0;
      beat     <= '0;
      starve   <= '0;
      we_l     <= 1'b0;
      i_rdata  <= '0;
      i_rvalid <= 1'b0;
      d_rdata  <= '0;
      d_rvalid <= 1'b0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_i) begin
            state  <= S_BI;
            owner  <= 2'b01;
            base   <= i_addr & LINE_MASK;
            beat   <= '0;
            we_l   <= 1'b0;
            starve <= '0;
          end else if (d_req) begin
            state <= S_BD;
            owner <= 2'b10;
            base  <= d_addr & LINE_MASK;
            beat  <= '0;
            we_l  <= d_we;
            if (i_req && starve != SMAX) starve <= starve + SW'(1);
          end
        end
        S_BI, S_BD: begin
          if (m_ack) begin
            beat <= beat + BW'(1);
            if (!we_l) begin
              if (state == S_BI) begin
                i_rdata  <= m_rdata;
                i_rvalid <= 1'b1;
              end else begin
                d_rdata  <= m_rdata;
                d_rvalid <= 1'b1;
              end
            end
            if (beat == LAST) state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          owner <= 2'b00;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Low address bits of base are zero, so OR-ing the beat offset wraps inside the line.
  assign m_req   = (state == S_BI) || (state == S_BD);
  assign m_we    = (state == S_BD) && we_l;
  assign m_addr  = m_req ? (base | AW'({beat, 2'b00})) : '0;
  assign m_wdata = m_we ? d_wdata : '0;
  assign d_wnext = m_we && m_ack;
  assign i_done  = (state == S_DONE) && (owner == 2'b01);
  assign d_done  = (state == S_DONE) && (owner == 2'b10);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: memory responder driven inline, read beats
// tracked through a scoreboard queue of {side, data}.
module tb_mem_port_arbiter;
  logic        Clk = 1'b0;
  logic        Rst;
  logic        i_req, d_req, d_we, m_ack;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_rvalid, i_done, d_wnext, d_rvalid, d_done, m_req, m_we;
  logic [1:0]  owner;

  int compared = 0, mismatched = 0;
  int i_done_cnt = 0, d_done_cnt = 0, wnext_cnt = 0;
  logic [32:0] sb[$];

  mem_port_arbiter #(.AW(32), .DW(32), .BURST(4), .STARVE_MAX(3)) dut (
    .Clk(Clk), .Rst(Rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wnext(d_wnext),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .owner(owner)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_rd(input logic side, input logic [31:0] data);
    logic [32:0] e;
    compared++;
    assert (sb.size() != 0) else begin
      mismatched++;
      $error("FAIL unexpected_rvalid observed=%0h expected=none", {side, data});
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rdata", {side, data}, e);
    end
  endtask

  // Called at each negedge: drains read beats and counts single-cycle pulses.
  task automatic observe();
    if (i_rvalid) pop_rd(1'b0, i_rdata);
    if (d_rvalid) pop_rd(1'b1, d_rdata);
    if (i_done)  i_done_cnt++;
    if (d_done)  d_done_cnt++;
    if (d_wnext) wnext_cnt++;
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge Clk); observe();
    chk({tag, "_owner"}, owner, 2'b00);
    chk({tag, "_m_req"}, m_req, 1'b0);
    @(posedge Clk); #1;
  endtask

  task automatic mem_burst(input logic isd, input logic we, input logic [31:0] base,
                           input int ws, input logic [31:0] dbase);
    for (int b = 0; b < 4; b++) begin
      d_wdata = 32'h5000 + 32'(b);
      for (int w = 0; w <= ws; w++) begin
        m_ack   = (w == ws);
        m_rdata = dbase + 32'(b);
        if (m_ack && !we) sb.push_back({isd, dbase + 32'(b)});
        @(negedge Clk); observe();
        chk("m_req", m_req, 1'b1);
        chk("m_addr", m_addr, base + 32'(4 * b));
        chk("m_we", m_we, we);
        chk("owner", owner, isd ? 2'b10 : 2'b01);
        if (we) begin
          chk("m_wdata", m_wdata, 32'h5000 + 32'(b));
          chk("d_wnext", d_wnext, m_ack);
        end
        @(posedge Clk); #1;
      end
    end
    m_ack = 1'b0; m_rdata = '0;
    @(negedge Clk); observe();
    chk("i_done", i_done, !isd);
    chk("d_done", d_done, isd);
    chk("m_req_done", m_req, 1'b0);
    if (!we) chk("last_rvalid", isd ? d_rvalid : i_rvalid, 1'b1);
    @(posedge Clk); #1;
  endtask

  initial begin
    Rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; m_ack = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
    repeat (2) @(posedge Clk);
    #1;
    @(negedge Clk);
    chk("rst_m_req", m_req, 1'b0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_owner", owner, 2'b00);
    chk("rst_rvalid", {i_rvalid, d_rvalid, i_done, d_done, d_wnext}, 5'b0);
    chk("rst_rdata", {i_rdata, d_rdata}, 64'h0);
    @(posedge Clk); #1;
    Rst = 1'b0;

    // Spurious ack while idle
    m_ack = 1'b1; m_rdata = 32'hDEAD;
    idle_cycle("spur0");
    idle_cycle("spur1");
    m_ack = 1'b0; m_rdata = '0;
    idle_cycle("spur2");

    // I-only read, unaligned address, back-to-back acks
    i_addr = 32'h1C; i_req = 1'b1;
    idle_cycle("i_grant");
    mem_burst(1'b0, 1'b0, 32'h10, 0, 32'hA0);
    i_req = 1'b0;
    idle_cycle("i_after");

    // D writeback with two wait states per beat
    d_addr = 32'h40; d_we = 1'b1; d_req = 1'b1;
    idle_cycle("dw_grant");
    mem_burst(1'b1, 1'b1, 32'h40, 2, 32'h0);
    d_req = 1'b0; d_we = 1'b0;
    idle_cycle("dw_after");
    chk("wnext_cnt", wnext_cnt, 4);

    // Simultaneous requests: D first, then I two cycles after d_done
    i_addr = 32'h20; d_addr = 32'h80; i_req = 1'b1; d_req = 1'b1;
    idle_cycle("both_grant");
    mem_burst(1'b1, 1'b0, 32'h80, 0, 32'hB0);
    d_req = 1'b0;
    idle_cycle("both_i_grant");
    mem_burst(1'b0, 1'b0, 32'h20, 0, 32'hB8);
    i_req = 1'b0;
    idle_cycle("both_after");

    // Starvation: three D bursts, forced I, then D again (counter cleared)
    i_addr = 32'h400; d_addr = 32'h300; i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle_cycle("starve_grant");
      mem_burst(1'b1, 1'b0, 32'h300, 0, 32'hD0 + 32'(k * 16));
    end
    idle_cycle("starve_i_grant");
    mem_burst(1'b0, 1'b0, 32'h400, 0, 32'hE0);
    idle_cycle("starve_d_again");
    mem_burst(1'b1, 1'b0, 32'h300, 1, 32'hF0);
    i_req = 1'b0; d_req = 1'b0;
    idle_cycle("starve_after");

    // Reset during beat 2 of an I burst
    i_addr = 32'h104; i_req = 1'b1;
    idle_cycle("rst_grant");
    for (int b = 0; b < 3; b++) begin
      m_ack = 1'b1; m_rdata = 32'h70 + 32'(b);
      if (b < 2) sb.push_back({1'b0, 32'h70 + 32'(b)});
      else Rst = 1'b1;
      @(negedge Clk); observe();
      chk("rst_burst_addr", m_addr, 32'h100 + 32'(4 * b));
      @(posedge Clk); #1;
    end
    m_ack = 1'b0; i_req = 1'b0;
    @(negedge Clk); observe();
    chk("rst_mid_m_req", m_req, 1'b0);
    chk("rst_mid_owner", owner, 2'b00);
    chk("rst_mid_done", {i_done, i_rvalid}, 2'b00);
    @(posedge Clk); #1;
    Rst = 1'b0;
    idle_cycle("post_rst");

    // Normal D refill after reset
    d_addr = 32'h204; d_we = 1'b0; d_req = 1'b1;
    idle_cycle("post_rst_grant");
    mem_burst(1'b1, 1'b0, 32'h200, 1, 32'hC0);
    d_req = 1'b0;
    idle_cycle("final_idle");
    idle_cycle("final_idle2");

    chk("i_done_cnt", i_done_cnt, 3);
    chk("d_done_cnt", d_done_cnt, 7);
    chk("wnext_total", wnext_cnt, 4);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single backing-memory port between instruction-cache refill (IF side, raised on Imiss) and data-cache refill/writeback (MA side, raised on Dmiss).
- Sequences one cache-line burst at a time and returns read words to the owning side.
- Sits between the IF/MA cache controllers and external memory. The stall logic keeps its pipeline stalls asserted until this block pulses done.

Parameters:
AW, 32, address width (byte address)
DW, 32, data width (one word = 4 bytes)
BURST, 4, words per line; power of two, >= 2
STARVE_MAX, 3, consecutive D grants allowed while I waits before I is forced

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  synchronous active-high reset
i_req  in  1  I-side line read request; held until i_done
i_addr  in  AW  I-side miss address, stable while i_req
i_rdata  out  DW  I-side read word
i_rvalid  out  1  i_rdata valid, one-cycle pulse per beat
i_done  out  1  I burst complete, one-cycle pulse
d_req  in  1  D-side request; held until d_done
d_we  in  1  1 = line writeback, 0 = line refill; stable while d_req
d_addr  in  AW  D-side address, stable while d_req
d_wdata  in  DW  current write word; advanced by requester on d_wnext
d_wnext  out  1  current d_wdata beat accepted
d_rdata  out  DW  D-side read word
d_rvalid  out  1  d_rdata valid pulse
d_done  out  1  D burst complete pulse
m_req  out  1  memory request, held for the whole burst
m_we  out  1  memory write
m_addr  out  AW  memory beat address
m_wdata  out  DW  memory write data (= d_wdata during D write)
m_rdata  in  DW  memory read data, valid with m_ack
m_ack  in  1  beat complete, one cycle per beat, any number of wait states
owner  out  2  00 idle, 01 I, 10 D (debug/hazard visibility)

Behaviour:
- Reset: state IDLE, beat counter 0, starve counter 0. All outputs 0 (m_addr and rdata outputs 0).
- FSM states: IDLE, BURST_I, BURST_D, DONE.
- IDLE arbitration, sampled each cycle:
  - Only i_req -> BURST_I.
  - Only d_req -> BURST_D.
  - Both -> BURST_D, unless starve counter == STARVE_MAX, then BURST_I.
  - Starve counter: +1 on each D grant while i_req is high (saturates at STARVE_MAX); cleared on every I grant.
- On grant:
  - Latch base = addr with the low log2(BURST*4) bits cleared; beat counter = 0.
  - For D, latch d_we.
  - owner set the same edge as the state change.
- BURST_x:
  - m_req = 1; m_addr = base + 4*beat (wraps within line, never crosses it); m_we = latched we (0 for I).
  - m_wdata = d_wdata combinationally.
  - d_wnext = m_ack && write burst, combinational in the ack cycle.
- On m_ack:
  - Beat counter +1.
  - On reads, rdata of the owning side <= m_rdata and its rvalid pulses the next cycle (latency 1); the other side's rvalid stays 0.
  - On ack of beat BURST-1 -> DONE; m_req deasserts that edge.
- DONE (one cycle):
  - Owner's done = 1, coincident with the last rvalid for reads.
  - m_req = 0; no arbitration this cycle.
  - Next state IDLE, owner -> 00.
- Requesters drop req in the cycle done is seen. A req still high in IDLE starts a new burst.
- req dropping mid-burst is illegal; the arbiter ignores it and completes the burst.
- m_ack while not in BURST_x is ignored.
- Rst mid-burst: immediate return to reset state next edge. Partial burst abandoned, no done pulse; memory side must be reset alongside.
- Maximum throughput: one beat per cycle with m_ack held high. A line takes BURST + 2 cycles from grant (1 grant + BURST beats + DONE).

Test Plan:
- I-only read, i_addr=0x0000_001C, m_ack every cycle, m_rdata=0xA0..0xA3 -> m_addr 0x10,0x14,0x18,0x1C; i_rvalid 4 pulses with 0xA0..0xA3; i_done with last rvalid; m_we=0; d_* outputs 0.
- D writeback, d_addr=0x40, m_ack with 2 wait states per beat -> m_we=1; m_addr 0x40..0x4C each held 3 cycles; d_wnext exactly 4 pulses aligned to m_ack; d_done once.
- i_req and d_req rise same cycle, starve=0 -> D burst first (owner=10); then I burst (owner=01) starting 2 cycles after d_done edge sequence (DONE, IDLE grant).
- d_req permanently reasserted, i_req held, STARVE_MAX=3 -> 3 D bursts, then I granted; starve counter 0 after I grant.
- Rst asserted during beat 2 of an I burst -> next cycle m_req=0, owner=00, i_done never pulses; after Rst release, a new d_req is granted normally.
- Spurious m_ack in IDLE -> no rvalid, no state change.
